// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, STATUS bit positions and TX FSM states for the MMIO UART
`timescale 1ns/1ps
package uart_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // A zero divisor would make every bit one cycle long with no reload margin; treat it as 1.
   function automatic logic [15:0] clamp_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head data and push-while-full-on-pop
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a push into a full FIFO is fine then.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx_responder.sv
// rtl/mmio_uart_tx_responder.sv - memory-mapped 8N1 UART transmitter on the core data port
`timescale 1ns/1ps
module mmio_uart_tx_responder
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          sel;
   logic [1:0]    offset;
   logic          push_req, push_ok, ovf_set, ovf_clr;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          busy, bit_end, load;
   logic [31:0]   status, rdata_d;
   logic          unused_bits;

   tx_state_t   state_q, state_d;
   logic [31:0] rdata_q;
   logic        ovf_q, ovf_d;
   logic [15:0] baud_q, baud_d;
   logic [15:0] fdiv_q, fdiv_d;
   logic [15:0] bcnt_q, bcnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        irq_q;

   assign unused_bits = &{1'b0, addr_i[1:0], wdata_i[31:16]};

   assign sel      = en_i && (addr_i[31:4] == BASE_ADDR[31:4]);
   assign offset   = addr_i[3:2];
   assign push_req = sel && (offset == REG_TXDATA) && we_i[0];
   assign push_ok  = !fifo_full || fifo_pop;
   assign ovf_set  = push_req && !push_ok;
   assign ovf_clr  = sel && (offset == REG_STATUS) && we_i[0] && wdata_i[ST_OVERFLOW];
   assign busy     = (state_q != TX_IDLE);

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_req),
      .din_i   (wdata_i[7:0]),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      status                          = '0;
      status[ST_BUSY]                 = busy;
      status[ST_FULL]                 = fifo_full;
      status[ST_EMPTY]                = fifo_empty;
      status[ST_OVERFLOW]             = ovf_q;
      status[ST_COUNT_LSB +: 8]       = 8'(fifo_count);
   end

   always_comb begin
      rdata_d = '0;
      if (sel && (we_i == 4'b0000)) begin
         case (offset)
            REG_STATUS:  rdata_d = status;
            REG_BAUDDIV: rdata_d = {16'h0000, baud_q};
            default:     rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      ovf_d  = ovf_q;
      baud_d = baud_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (sel && (offset == REG_BAUDDIV)) begin
         if (we_i[0]) baud_d[7:0]  = wdata_i[7:0];
         if (we_i[1]) baud_d[15:8] = wdata_i[15:8];
      end
   end

   // Baud counter runs div..0, so each bit lasts div+1 cycles; the frame divisor is
   // latched at every pop so a BAUDDIV write never disturbs a frame in flight.
   always_comb begin
      state_d  = state_q;
      fdiv_d   = fdiv_q;
      bcnt_d   = bcnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      load     = 1'b0;
      bit_end  = (bcnt_q == 16'd0);
      case (state_q)
         TX_IDLE: begin
            load = !fifo_empty;
         end
         TX_START: begin
            if (bit_end) begin
               bcnt_d  = fdiv_q;
               idx_d   = 3'd0;
               state_d = TX_DATA;
            end else begin
               bcnt_d = bcnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               bcnt_d  = fdiv_q;
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = TX_STOP;
            end else begin
               bcnt_d = bcnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               load    = !fifo_empty;
               state_d = TX_IDLE;
            end else begin
               bcnt_d = bcnt_q - 16'd1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_dout;
         fdiv_d   = clamp_div(baud_q);
         bcnt_d   = clamp_div(baud_q);
         state_d  = TX_START;
      end
      case (state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= TX_IDLE;
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         baud_q  <= DEFAULT_DIV;
         fdiv_q  <= clamp_div(DEFAULT_DIV);
         bcnt_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         baud_q  <= baud_d;
         fdiv_q  <= fdiv_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         irq_q   <= fifo_empty && !busy;
      end
   end

   assign rdata_o = rdata_q;
   assign tx_o    = tx_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// tb/tb_mmio_uart_tx_responder.sv - directed scoreboard bench for the MMIO UART transmitter
`timescale 1ns/1ps
module tb_mmio_uart_tx_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [3:0]  we_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        tx_o;
   logic        irq_o;

   int passed = 0;
   int total  = 0;

   logic [31:0] rd_sb [$];
   logic [15:0] tx_sb [$];

   mmio_uart_tx_responder #(
      .BASE_ADDR   (BASE),
      .FIFO_DEPTH  (16),
      .DEFAULT_DIV (16'd867)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .addr_i  (addr_i),
      .we_i    (we_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .tx_o    (tx_o),
      .irq_o   (irq_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      en_i    = 1'b1;
      addr_i  = a;
      we_i    = w;
      wdata_i = d;
      @(negedge clk_i);
      en_i    = 1'b0;
      addr_i  = '0;
      we_i    = '0;
      wdata_i = '0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] e;
      rd_sb.push_back(exp);
      access(a, 4'b0000, 32'h0);
      e = rd_sb.pop_front();
      chk(tag, rdata_o, e);
   endtask

   task automatic store(input logic [7:0] b, input logic [7:0] bitlen, input logic accepted,
                        input logic [3:0] w);
      if (accepted) tx_sb.push_back({bitlen, b});
      access(BASE, w, {24'hA5C3E1, b});
   endtask

   // Call on the falling edge right after the edge that made the byte available to the FSM.
   task automatic run_frame();
      logic [15:0] e;
      logic [9:0]  bits;
      int          bl;
      if (tx_sb.size() == 0) begin
         total++;
         $error("FAIL tx_sb: observed empty scoreboard expected a pending byte");
         return;
      end
      e    = tx_sb.pop_front();
      bits = {1'b1, e[7:0], 1'b0};
      bl   = int'(e[15:8]);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < bl; j++) begin
            @(negedge clk_i);
            chk($sformatf("tx_%02h_bit%0d_c%0d", e[7:0], i, j), 32'(tx_o), 32'(bits[i]));
         end
      end
   endtask

   initial begin
      // 1: reset and idle
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (20) @(negedge clk_i);
      chk("idle_tx", 32'(tx_o), 32'd1);
      chk("idle_irq", 32'(irq_o), 32'd1);
      rd("rst_status", BASE + 32'h4, 32'h0000_0004);
      rd("rst_txdata", BASE + 32'h0, 32'h0000_0000);
      rd("rst_baud", BASE + 32'h8, 32'h0000_0363);

      // 2: single 0x55 frame at div=3
      access(BASE + 32'h8, 4'b0011, 32'hFFFF_0003);
      rd("baud3", BASE + 32'h8, 32'h0000_0003);
      store(8'h55, 8'd4, 1'b1, 4'b0001);
      run_frame();
      repeat (3) @(negedge clk_i);
      chk("t2_irq", 32'(irq_o), 32'd1);
      rd("t2_status", BASE + 32'h4, 32'h0000_0004);

      // 3 + 4: fill, overflow, W1C, push into full FIFO during a STOP->START pop
      fork
         begin
            for (int i = 0; i < 17; i++) begin
               store(8'h30 + 8'(i), 8'd4, 1'b1, (i == 5) ? 4'b1111 : 4'b0001);
            end
            store(8'hEE, 8'd4, 1'b0, 4'b0001);
            chk("t3_irq_busy", 32'(irq_o), 32'd0);
            rd("ovf_status", BASE + 32'h4, 32'h0000_100B);
            access(BASE + 32'h4, 4'b0001, 32'h0000_0008);
            rd("w1c_status", BASE + 32'h4, 32'h0000_1003);
            repeat (20) @(negedge clk_i);
            store(8'hC7, 8'd4, 1'b1, 4'b0001);
            rd("full_pop_push", BASE + 32'h4, 32'h0000_1003);
         end
         begin
            @(negedge clk_i);
            for (int f = 0; f < 18; f++) run_frame();
         end
      join
      repeat (3) @(negedge clk_i);
      chk("t3_irq", 32'(irq_o), 32'd1);
      rd("t3_status", BASE + 32'h4, 32'h0000_0004);

      // 5: reset during DATA bit 3
      store(8'hA5, 8'd4, 1'b0, 4'b0001);
      store(8'h3C, 8'd4, 1'b0, 4'b0001);
      repeat (17) @(negedge clk_i);
      chk("t5_bit3", 32'(tx_o), 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("t5_rst_tx", 32'(tx_o), 32'd1);
      chk("t5_rst_irq", 32'(irq_o), 32'd1);
      rst_i = 1'b0;
      rd("t5_status", BASE + 32'h4, 32'h0000_0004);
      rd("t5_baud", BASE + 32'h8, 32'h0000_0363);

      // 6: BAUDDIV change mid-frame, unselected and unmapped accesses
      access(BASE + 32'h8, 4'b0011, 32'h0000_0003);
      fork
         begin
            store(8'h96, 8'd4, 1'b1, 4'b0001);
            access(BASE + 32'h8, 4'b0011, 32'h0000_0007);
            store(8'h69, 8'd8, 1'b1, 4'b0001);
            access(32'h0FFF_FFF0, 4'b1111, 32'h0000_005A);
            rd("nosel_rd", 32'h0FFF_FFF0, 32'h0000_0000);
            access(BASE + 32'hC, 4'b1111, 32'hFFFF_FFFF);
            rd("unmapped_rd", BASE + 32'hC, 32'h0000_0000);
            rd("t6_status", BASE + 32'h4, 32'h0000_0101);
            rd("baud7", BASE + 32'h8, 32'h0000_0007);
         end
         begin
            @(negedge clk_i);
            run_frame();
            run_frame();
         end
      join
      repeat (3) @(negedge clk_i);
      chk("t6_irq", 32'(irq_o), 32'd1);
      rd("t6_end_status", BASE + 32'h4, 32'h0000_0004);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
